// File: rtl/rr_credit_dispatcher.sv
// rr_credit_dispatcher
// Distributes one valid/ready stream across NumOut consumers in round-robin
// order. Each consumer has a credit counter that limits how many beats it can
// have outstanding. Once a target has been offered a beat, that target is held
// until the beat is accepted.
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   flush_i      returns the round-robin pointer to output 0
//   valid_i      input beat valid
//   ready_o      input beat accepted (combinational from ready_i)
//   data_i       input payload
//   valid_o      per-output valid, one-hot or zero
//   ready_i      per-output ready
//   data_o       data_i copied to every output slice
//   credit_i     per-output credit return, one pulse per credit
//   idx_o        index of the current target
//   credit_err_o one-cycle pulse after a credit return into a full counter
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | a new target is chosen each cycle from rr_q and the credits
// LOCKED | a beat was offered to sel_q and not accepted; sel_q is held

module rr_credit_dispatcher #(
    parameter int NumOut     = 4,
    parameter int DataWidth  = 32,
    parameter int MaxCredits = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          flush_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    input  logic [DataWidth-1:0]          data_i,
    output logic [NumOut-1:0]             valid_o,
    input  logic [NumOut-1:0]             ready_i,
    output logic [NumOut*DataWidth-1:0]   data_o,
    input  logic [NumOut-1:0]             credit_i,
    output logic [$clog2(NumOut)-1:0]     idx_o,
    output logic                          credit_err_o
);

    localparam int CntW = $clog2(MaxCredits + 1);
    localparam int IdxW = $clog2(NumOut);
    localparam logic [CntW-1:0] CntMax  = CntW'(MaxCredits);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(NumOut - 1);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t            state_q, state_d;
    logic [IdxW-1:0]   rr_q;
    logic [IdxW-1:0]   sel_q;
    logic [CntW-1:0]   cnt_q [NumOut];
    logic              credit_err_q;

    logic [NumOut-1:0] eligible;
    logic              any_eligible;
    logic [IdxW-1:0]   sel;
    logic [NumOut-1:0] dispatch;
    logic [NumOut-1:0] overflow;
    int                pos;

    always_comb begin
        for (int j = 0; j < NumOut; j++) begin
            eligible[j] = (cnt_q[j] != '0);
        end
    end

    // Scan starting at rr_q and take the first output that still has credit.
    always_comb begin
        sel          = '0;
        any_eligible = 1'b0;
        pos          = 0;
        for (int k = 0; k < NumOut; k++) begin
            pos = int'(rr_q) + k;
            if (pos >= NumOut) begin
                pos = pos - NumOut;
            end
            if (!any_eligible && eligible[pos]) begin
                any_eligible = 1'b1;
                sel          = IdxW'(pos);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        valid_o = '0;
        idx_o   = sel;
        case (state_q)
            IDLE: begin
                if (valid_i && any_eligible) begin
                    valid_o[sel] = 1'b1;
                    if (!ready_i[sel]) begin
                        state_d = LOCKED;
                    end
                end
            end
            LOCKED: begin
                // An offered beat is never withdrawn, so valid_i is not consulted.
                idx_o          = sel_q;
                valid_o[sel_q] = 1'b1;
                if (ready_i[sel_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (rst_i) begin
            valid_o = '0;
        end
    end

    assign dispatch     = valid_o & ready_i;
    assign ready_o      = |dispatch;
    assign data_o       = {NumOut{data_i}};
    assign credit_err_o = credit_err_q & ~rst_i;

    always_comb begin
        for (int j = 0; j < NumOut; j++) begin
            overflow[j] = credit_i[j] && !dispatch[j] && (cnt_q[j] == CntMax);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE) begin
                sel_q <= sel;
            end
        end
    end

    // A flush in the same cycle as a handshake takes priority.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q <= '0;
        end else if (flush_i) begin
            rr_q <= '0;
        end else if (ready_o) begin
            rr_q <= (idx_o == IdxLast) ? '0 : idx_o + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int j = 0; j < NumOut; j++) begin
                cnt_q[j] <= CntMax;
            end
            credit_err_q <= 1'b0;
        end else begin
            for (int j = 0; j < NumOut; j++) begin
                case ({dispatch[j], credit_i[j]})
                    2'b10:   cnt_q[j] <= cnt_q[j] - 1'b1;
                    2'b01:   if (cnt_q[j] != CntMax) cnt_q[j] <= cnt_q[j] + 1'b1;
                    default: cnt_q[j] <= cnt_q[j];
                endcase
            end
            credit_err_q <= |overflow;
        end
    end

endmodule

// File: tb/tb_rr_credit_dispatcher.sv
module tb_rr_credit_dispatcher;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         flush_i;
    logic         valid_i;
    logic         ready_o;
    logic [31:0]  data_i;
    logic [3:0]   valid_o;
    logic [3:0]   ready_i;
    logic [127:0] data_o;
    logic [3:0]   credit_i;
    logic [1:0]   idx_o;
    logic         credit_err_o;

    int n_vec  = 0;
    int n_miss = 0;

    rr_credit_dispatcher #(
        .NumOut(4), .DataWidth(32), .MaxCredits(4)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
        .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
        .credit_i(credit_i), .idx_o(idx_o), .credit_err_o(credit_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_cnts(input string tag, input int e0, input int e1, input int e2, input int e3);
        chk({tag, " cnt0"}, 32'(dut.cnt_q[0]), e0);
        chk({tag, " cnt1"}, 32'(dut.cnt_q[1]), e1);
        chk({tag, " cnt2"}, 32'(dut.cnt_q[2]), e2);
        chk({tag, " cnt3"}, 32'(dut.cnt_q[3]), e3);
    endtask

    // One cycle with valid_i high; exp_t < 0 means no output is eligible.
    task automatic beat(input string tag, input int exp_t, input logic [31:0] d);
        valid_i = 1'b1;
        data_i  = d;
        @(negedge clk_i);
        if (exp_t < 0) begin
            chk({tag, " valid_o"}, 32'(valid_o), 0);
            chk({tag, " ready_o"}, 32'(ready_o), 0);
        end else begin
            chk({tag, " valid_o"}, 32'(valid_o), 1 << exp_t);
            chk({tag, " idx_o"},   32'(idx_o), exp_t);
            chk({tag, " ready_o"}, 32'(ready_o), 32'(ready_i[exp_t]));
            chk({tag, " data_o"},  data_o[exp_t*32 +: 32], d);
        end
        step();
    endtask

    initial begin
        int t3 [16] = '{2, 3, 0, 1, 2, 3, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1};
        int t4 [5]  = '{3, 0, 2, 3, 0};

        rst_i    = 1'b1;
        flush_i  = 1'b0;
        valid_i  = 1'b1;
        data_i   = 32'h0;
        ready_i  = 4'hF;
        credit_i = 4'h0;
        step();
        @(negedge clk_i);
        chk("rst valid_o", 32'(valid_o), 0);
        chk("rst ready_o", 32'(ready_o), 0);
        chk("rst err",     32'(credit_err_o), 0);
        step();
        rst_i   = 1'b0;
        valid_i = 1'b0;
        @(negedge clk_i);
        chk_cnts("post rst", 4, 4, 4, 4);
        chk("post rst rr", 32'(dut.rr_q), 0);
        step();

        // 1: eight back-to-back beats, all ready
        for (int k = 0; k < 8; k++) begin
            beat("t1", k % 4, 32'(k));
        end
        valid_i = 1'b0;
        @(negedge clk_i);
        chk_cnts("t1", 2, 2, 2, 2);
        step();

        // 2: beat to 0, then target 1 stalls three cycles
        beat("t2 pre", 0, 32'h100);
        ready_i = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            beat("t2 stall", 1, 32'hA);
        end
        ready_i = 4'hF;
        beat("t2 accept", 1, 32'hA);
        valid_i = 1'b0;
        @(negedge clk_i);
        chk_cnts("t2", 1, 1, 2, 2);
        step();

        // 3: drain every credit, then return one to output 2
        for (int k = 0; k < 16; k++) begin
            beat("t3 drain", t3[k], 32'(k + 32'h200));
        end
        credit_i = 4'b0100;
        beat("t3 credit cycle", -1, 32'h300);
        credit_i = 4'b0000;
        beat("t3 after credit", 2, 32'h301);
        beat("t3 empty again", -1, 32'h302);
        valid_i = 1'b0;

        // 4: refill all but output 1, then skip it and wrap
        credit_i = 4'b1101;
        for (int k = 0; k < 4; k++) step();
        credit_i = 4'b0000;
        @(negedge clk_i);
        chk_cnts("t4 refill", 4, 0, 4, 4);
        chk("t4 rr", 32'(dut.rr_q), 3);
        step();
        for (int k = 0; k < 5; k++) begin
            beat("t4", t4[k], 32'(k + 32'h400));
        end
        valid_i = 1'b0;
        @(negedge clk_i);
        chk_cnts("t4", 2, 0, 3, 2);
        step();

        // 5: credit and dispatch together, then overflow
        flush_i = 1'b1;
        step();
        flush_i  = 1'b0;
        credit_i = 4'b0001;
        beat("t5 same cycle", 0, 32'h500);
        credit_i = 4'b0000;
        valid_i  = 1'b0;
        @(negedge clk_i);
        chk("t5 cnt0", 32'(dut.cnt_q[0]), 2);
        chk("t5 rr", 32'(dut.rr_q), 1);
        step();
        credit_i = 4'b1000;
        step();
        @(negedge clk_i);
        chk("t5 no err", 32'(credit_err_o), 0);
        step();
        @(negedge clk_i);
        chk("t5 cnt3 full", 32'(dut.cnt_q[3]), 4);
        step();
        credit_i = 4'b0000;
        @(negedge clk_i);
        chk("t5 err pulse", 32'(credit_err_o), 1);
        chk("t5 cnt3 held", 32'(dut.cnt_q[3]), 4);
        step();
        @(negedge clk_i);
        chk("t5 err clear", 32'(credit_err_o), 0);
        step();

        // 6: flush while locked, flush with handshake, reset while locked
        ready_i = 4'b0000;
        beat("t6 lock", 2, 32'h600);
        flush_i = 1'b1;
        beat("t6 flush held", 2, 32'h600);
        ready_i = 4'b0100;
        beat("t6 flush+hs", 2, 32'h600);
        flush_i = 1'b0;
        ready_i = 4'hF;
        beat("t6 after flush", 0, 32'h601);
        ready_i = 4'b0000;
        beat("t6 lock2", 2, 32'h602);
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("t6 rst valid_o", 32'(valid_o), 0);
        chk("t6 rst ready_o", 32'(ready_o), 0);
        step();
        rst_i   = 1'b0;
        valid_i = 1'b0;
        @(negedge clk_i);
        chk_cnts("t6 rst", 4, 4, 4, 4);
        chk("t6 rst rr", 32'(dut.rr_q), 0);
        chk("t6 rst idle valid_o", 32'(valid_o), 0);
        step();
        ready_i = 4'hF;
        beat("t6 restart", 0, 32'h603);
        valid_i = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
